// File: rtl/ahb_dma_slave_mem.sv
// AHB-Lite responder terminating DMA transfers into a small word buffer.
// Adds fixed wait states, flags illegal accesses with a two-cycle ERROR, and pulses done per write block.
module ahb_dma_slave_mem #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned LEN_W       = 8
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              hsel,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [31:0]       hwdata,
   input  logic              hready_i,
   output logic [31:0]       hrdata,
   output logic              hready_o,
   output logic              hresp,
   input  logic [LEN_W-1:0]  expect_len,
   output logic              done
);

   localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned WCNT_W  = 4;
   localparam logic [WCNT_W-1:0] WS_LOAD =
      (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t              state, state_nx;
   logic [WCNT_W-1:0]   wcnt, wcnt_nx;
   logic [IDX_W-1:0]    idx_q;
   logic                wr_q;
   logic [LEN_W-1:0]    beat_cnt;
   logic [31:0]         mem [DEPTH];

   logic                acc_c, err_c, oob_c, cap_c;
   logic [IDX_W-1:0]    addr_idx_c, rd_idx_c;
   logic                rd_wr_c, commit_c, load_rd_c, done_nx_c;
   logic [LEN_W-1:0]    beat_inc_c;
   logic [31:0]         rd_word_c;

   // Bytes beyond the buffer: any address bit above the word index is set.
   generate
      if (ADDR_W > IDX_W + 2) begin : g_oob
         assign oob_c = |haddr[ADDR_W-1:IDX_W+2];
      end else begin : g_no_oob
         assign oob_c = 1'b0;
      end
   endgenerate

   assign addr_idx_c = haddr[IDX_W+1:2];
   assign acc_c      = hsel & htrans[1] & hready_i;
   assign err_c      = (hsize != 3'b010) | (haddr[1:0] != 2'b00) | oob_c;

   always_comb begin
      state_nx = state;
      wcnt_nx  = wcnt;
      cap_c    = 1'b0;
      case (state)
         S_IDLE, S_DATA, S_ERR2: begin
            state_nx = S_IDLE;
            if (acc_c) begin
               cap_c = 1'b1;
               if (err_c) begin
                  state_nx = S_ERR1;
               end else if (WAIT_STATES == 0) begin
                  state_nx = S_DATA;
               end else begin
                  state_nx = S_WAIT;
                  wcnt_nx  = WS_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (wcnt == '0) state_nx = S_DATA;
            else            wcnt_nx  = wcnt - WCNT_W'(1);
         end
         S_ERR1:  state_nx = S_ERR2;
         default: state_nx = S_IDLE;
      endcase
   end

   // The transfer entering DATA is the one captured now (zero-wait) or the latched one.
   always_comb begin
      rd_idx_c   = cap_c ? addr_idx_c : idx_q;
      rd_wr_c    = cap_c ? hwrite : wr_q;
      commit_c   = (state == S_DATA) && wr_q;
      load_rd_c  = (state_nx == S_DATA) && !rd_wr_c;
      rd_word_c  = (commit_c && (idx_q == rd_idx_c)) ? hwdata : mem[rd_idx_c];
      beat_inc_c = beat_cnt + LEN_W'(1);
      done_nx_c  = commit_c && (expect_len != '0) && (beat_inc_c == expect_len);
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state    <= S_IDLE;
         wcnt     <= '0;
         idx_q    <= '0;
         wr_q     <= 1'b0;
         hready_o <= 1'b1;
         hresp    <= 1'b0;
         hrdata   <= '0;
         done     <= 1'b0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nx;
         wcnt     <= wcnt_nx;
         if (cap_c) begin
            idx_q <= addr_idx_c;
            wr_q  <= hwrite;
         end
         hready_o <= !((state_nx == S_WAIT) || (state_nx == S_ERR1));
         hresp    <= (state_nx == S_ERR1) || (state_nx == S_ERR2);
         hrdata   <= load_rd_c ? rd_word_c : '0;
         done     <= done_nx_c;
         if (commit_c) beat_cnt <= done_nx_c ? '0 : beat_inc_c;
      end
   end

   // Buffer contents survive reset; reset clears state so no commit follows it.
   always_ff @(posedge hclk) begin
      if (commit_c && !hreset) mem[idx_q] <= hwdata;
   end

endmodule

// File: tb/tb_ahb_dma_slave_mem.sv
// Directed bench for ahb_dma_slave_mem: one instance with one wait state, one with none.
`timescale 1ns/1ps
module tb_ahb_dma_slave_mem;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        hsel0, hsel1;
   logic [7:0]  haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic [7:0]  expect_len;
   logic [31:0] hrdata0, hrdata1;
   logic        hready0, hready1, hresp0, hresp1, done0, done1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 hclk = ~hclk;

   ahb_dma_slave_mem #(.DEPTH(16), .ADDR_W(8), .WAIT_STATES(0), .LEN_W(8)) u_ws0 (
      .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_i(hready0),
      .hrdata(hrdata0), .hready_o(hready0), .hresp(hresp0),
      .expect_len(expect_len), .done(done0));

   ahb_dma_slave_mem #(.DEPTH(16), .ADDR_W(8), .WAIT_STATES(1), .LEN_W(8)) u_ws1 (
      .hclk(hclk), .hreset(hreset), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_i(hready1),
      .hrdata(hrdata1), .hready_o(hready1), .hresp(hresp1),
      .expect_len(expect_len), .done(done1));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic bus_idle();
      hsel0  = 1'b0;
      hsel1  = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
   endtask

   // One unpipelined transfer; reports data/resp at completion, wait cycles, and done after it.
   task automatic xfer(input bit on1, input bit wr, input logic [7:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                       output int nw, output logic dn);
      hsel0 = !on1; hsel1 = on1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
      tick();
      bus_idle();
      hwdata = wd;
      nw = 0;
      while (((on1 ? hready1 : hready0) == 1'b0) && nw < 20) begin
         tick();
         nw++;
      end
      if (nw >= 20) check("xfer_timeout", 32'(nw), 32'd0);
      rd  = on1 ? hrdata1 : hrdata0;
      rsp = on1 ? hresp1 : hresp0;
      tick();
      dn  = on1 ? done1 : done0;
      hsize = 3'b010;
   endtask

   logic [7:0]  err_addr [3] = '{8'h40, 8'h02, 8'h0C};
   logic [2:0]  err_size [3] = '{3'b010, 3'b010, 3'b001};
   logic [7:0]  d_addr   [5] = '{8'h00, 8'h04, 8'h42, 8'h08, 8'h0C};
   logic        d_resp   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic        d_done   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      logic [31:0] rd;
      logic        rsp, dn, any_done;
      int          nw;

      hreset = 1'b1; bus_idle(); haddr = '0; hsize = 3'b010; hwdata = '0; expect_len = '0;
      tick(); tick();
      check("rst_rdy0", 32'(hready0), 32'd1);
      check("rst_rdy1", 32'(hready1), 32'd1);
      check("rst_resp1", 32'(hresp1), 32'd0);
      check("rst_rdata1", hrdata1, 32'd0);
      check("rst_done0", 32'(done0), 32'd0);
      hreset = 1'b0;
      tick();

      // Single write then read with one wait state
      hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 8'h0C;
      check("t1_addr_rdy", 32'(hready1), 32'd1);
      tick(); bus_idle(); hwdata = 32'hDEADBEEF;
      check("t1_wr_wait_rdy", 32'(hready1), 32'd0);
      check("t1_wr_wait_resp", 32'(hresp1), 32'd0);
      tick();
      check("t1_wr_data_rdy", 32'(hready1), 32'd1);
      check("t1_wr_data_rdata", hrdata1, 32'd0);
      tick();
      hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 8'h0C;
      tick(); bus_idle();
      check("t1_rd_wait_rdy", 32'(hready1), 32'd0);
      check("t1_rd_wait_rdata", hrdata1, 32'd0);
      tick();
      check("t1_rd_data_rdy", 32'(hready1), 32'd1);
      check("t1_rd_data_resp", 32'(hresp1), 32'd0);
      check("t1_rd_data", hrdata1, 32'hDEADBEEF);
      tick();
      check("t1_rd_after", hrdata1, 32'd0);

      // Back-to-back zero-wait writes then reads
      hsel0 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         hwdata = 32'(i + 1);
         if (i < 2) haddr = 8'((i + 1) * 4);
         else bus_idle();
         check("t2_wr_rdy", 32'(hready0), 32'd1);
      end
      tick();
      hsel0 = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i < 2) haddr = 8'((i + 1) * 4);
         else bus_idle();
         check("t2_rd_rdy", 32'(hready0), 32'd1);
         check("t2_rd_data", hrdata0, 32'(i + 1));
      end
      tick();
      check("t2_rd_after", hrdata0, 32'd0);

      // Read issued during the write's data phase sees the new word
      hsel0 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 8'h10;
      tick();
      hwdata = 32'h12345678; hwrite = 1'b0;
      tick(); bus_idle();
      check("t3_fwd_data", hrdata0, 32'h12345678);
      tick();

      // Error responses leave memory untouched
      xfer(1'b1, 1'b1, 8'h00, 3'b010, 32'h11110000, rd, rsp, nw, dn);
      check("t4_pre_resp", 32'(rsp), 32'd0);
      for (int i = 0; i < 3; i++) begin
         xfer(1'b1, 1'b1, err_addr[i], err_size[i], 32'hFFFFFFFF, rd, rsp, nw, dn);
         check("t4_err_waits", 32'(nw), 32'd1);
         check("t4_err_resp", 32'(rsp), 32'd1);
      end
      xfer(1'b1, 1'b0, 8'h40, 3'b010, 32'h0, rd, rsp, nw, dn);
      check("t4_err_rd_resp", 32'(rsp), 32'd1);
      check("t4_err_rd_data", rd, 32'd0);
      xfer(1'b1, 1'b0, 8'h00, 3'b010, 32'h0, rd, rsp, nw, dn);
      check("t4_mem0", rd, 32'h11110000);
      xfer(1'b1, 1'b0, 8'h0C, 3'b010, 32'h0, rd, rsp, nw, dn);
      check("t4_mem0c", rd, 32'hDEADBEEF);
      check("t4_mem0c_waits", 32'(nw), 32'd1);

      // Reset during a write's wait cycle drops the write
      xfer(1'b1, 1'b1, 8'h04, 3'b010, 32'hA5A5A5A5, rd, rsp, nw, dn);
      hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 8'h04;
      tick(); bus_idle(); hwdata = 32'h0;
      check("t6_wait_rdy", 32'(hready1), 32'd0);
      hreset = 1'b1;
      #1;
      check("t6_rst_rdy", 32'(hready1), 32'd1);
      check("t6_rst_resp", 32'(hresp1), 32'd0);
      check("t6_rst_rdata", hrdata1, 32'd0);
      check("t6_rst_done", 32'(done1), 32'd0);
      tick();
      hreset = 1'b0;
      tick();
      xfer(1'b1, 1'b0, 8'h04, 3'b010, 32'h0, rd, rsp, nw, dn);
      check("t6_mem_kept", rd, 32'hA5A5A5A5);

      // done after the fourth OKAY write; error beat not counted
      expect_len = 8'd4;
      for (int i = 0; i < 5; i++) begin
         xfer(1'b0, 1'b1, d_addr[i], 3'b010, 32'(100 + i), rd, rsp, nw, dn);
         check("t5_resp", 32'(rsp), 32'(d_resp[i]));
         check("t5_done", 32'(dn), 32'(d_done[i]));
      end
      tick();
      check("t5_done_pulse", 32'(done0), 32'd0);
      for (int i = 0; i < 4; i++) begin
         xfer(1'b0, 1'b1, 8'(4 * i), 3'b010, 32'(200 + i), rd, rsp, nw, dn);
         check("t5_done_restart", 32'(dn), (i == 3) ? 32'd1 : 32'd0);
      end
      expect_len = 8'd0;
      any_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         xfer(1'b0, 1'b1, 8'(4 * (i % 16)), 3'b010, 32'(i), rd, rsp, nw, dn);
         any_done = any_done | dn;
      end
      check("t5_len0_nodone", 32'(any_done), 32'd0);
      xfer(1'b0, 1'b0, 8'h24, 3'b010, 32'h0, rd, rsp, nw, dn);
      check("t5_last_wr", rd, 32'd9);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
